// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc
//   Multi-cycle hazard controller for the 5-stage pipeline. It drives the
//   hold and bubble controls for the PC and the FD/DE/EM/MW pipeline
//   registers. It covers load-use stalls, data-memory wait, squash of
//   wrong-path fetches after a redirect, a sticky halt and a saturating
//   count of stalled cycles.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   RUN   | normal flow; checks for load-use and imem stalls
//   LDUSE | extra load-use bubble cycles, ld_cnt remaining
//   FLUSH | squashing wrong-path fetches, fl_cnt remaining
//   DWAIT | data memory busy; LDUSE/FLUSH progress is frozen
//   HALT  | sticky halt, left only by reset
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   redirect            taken branch/jump resolved in EX
//   halt                halt/dump request from decode
//   imem_stall          instruction memory not ready
//   dmem_stall          data memory busy
//   id_ex_mem_read      EX instruction is a load
//   id_ex_rd            load destination register
//   if_id_rs/rt(_vld)   decode source registers and their read enables
//   pc_hold, fd_hold, de_hold, em_hold    register hold controls
//   fd_nop, de_nop, mw_nop                bubble inserts
//   halted              pipeline is halted
//   stall_cnt           saturating count of cycles with the PC held
module hazard_ctrl_mc #(
  parameter int REG_W         = 3,
  parameter int LOAD_LAT      = 1,
  parameter int IMEM_LAT      = 1,
  parameter int ZERO_REG_HARD = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic             halt,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_rs_vld,
  input  logic             if_id_rt_vld,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             de_hold,
  output logic             em_hold,
  output logic             fd_nop,
  output logic             de_nop,
  output logic             mw_nop,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LD_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int FL_W = (IMEM_LAT > 0) ? $clog2(IMEM_LAT + 1) : 1;
  localparam logic [LD_W-1:0]  LD_INIT = LD_W'((LOAD_LAT > 1) ? LOAD_LAT - 1 : 0);
  localparam logic [FL_W-1:0]  FL_INIT = FL_W'(IMEM_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_LDUSE = 3'd1,
    S_FLUSH = 3'd2,
    S_DWAIT = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           state_q, state_d, eff_state;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [FL_W-1:0]  fl_cnt_q, fl_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             ld_hit;
  logic             rs_match, rt_match, rd_masked;

  // raw next-cycle controls before the reset gate
  logic pc_hold_c, fd_hold_c, de_hold_c, em_hold_c;
  logic fd_nop_c, de_nop_c, mw_nop_c, halted_c;

  assign rs_match  = if_id_rs_vld && (if_id_rs == id_ex_rd);
  assign rt_match  = if_id_rt_vld && (if_id_rt == id_ex_rd);
  assign rd_masked = (ZERO_REG_HARD != 0) && (id_ex_rd == '0);
  assign ld_hit    = id_ex_mem_read && (rs_match || rt_match) && !rd_masked;

  // DWAIT does not record what it interrupted: a non-zero counter means an
  // LDUSE or FLUSH was frozen and resumes once data memory is ready.
  always_comb begin
    eff_state = state_q;
    if (state_q == S_DWAIT) begin
      if (ld_cnt_q != '0)      eff_state = S_LDUSE;
      else if (fl_cnt_q != '0) eff_state = S_FLUSH;
      else                     eff_state = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      ld_cnt_q     <= '0;
      fl_cnt_q     <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      fl_cnt_q     <= fl_cnt_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  always_comb begin
    pc_hold_c    = 1'b0;
    fd_hold_c    = 1'b0;
    de_hold_c    = 1'b0;
    em_hold_c    = 1'b0;
    fd_nop_c     = 1'b0;
    de_nop_c     = 1'b0;
    mw_nop_c     = 1'b0;
    halted_c     = 1'b0;
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    fl_cnt_d     = fl_cnt_q;
    redir_pend_d = redir_pend_q;

    if (state_q == S_HALT) begin
      {pc_hold_c, fd_hold_c, de_hold_c, em_hold_c} = 4'b1111;
      mw_nop_c = 1'b1;
      halted_c = 1'b1;
    end else if (halt) begin
      {pc_hold_c, fd_hold_c, de_hold_c, em_hold_c} = 4'b1111;
      mw_nop_c = 1'b1;
      state_d  = S_HALT;
    end else if (dmem_stall) begin
      {pc_hold_c, fd_hold_c, de_hold_c, em_hold_c} = 4'b1111;
      mw_nop_c = 1'b1;
      state_d  = S_DWAIT;
      // the redirect is remembered and replayed once memory is ready
      if (redirect) redir_pend_d = 1'b1;
    end else if (redirect || redir_pend_q) begin
      fd_nop_c     = 1'b1;
      de_nop_c     = 1'b1;
      redir_pend_d = 1'b0;
      ld_cnt_d     = '0;
      fl_cnt_d     = FL_INIT;
      state_d      = (IMEM_LAT > 0) ? S_FLUSH : S_RUN;
    end else begin
      case (eff_state)
        S_LDUSE: begin
          pc_hold_c = 1'b1;
          fd_hold_c = 1'b1;
          de_nop_c  = 1'b1;
          ld_cnt_d  = ld_cnt_q - LD_W'(1);
          state_d   = (ld_cnt_q == LD_W'(1)) ? S_RUN : S_LDUSE;
        end
        S_FLUSH: begin
          // FD is being squashed anyway, so load-use is not checked here
          fd_nop_c  = 1'b1;
          pc_hold_c = imem_stall;
          fl_cnt_d  = fl_cnt_q - FL_W'(1);
          state_d   = (fl_cnt_q == FL_W'(1)) ? S_RUN : S_FLUSH;
        end
        default: begin
          state_d = S_RUN;
          if (ld_hit) begin
            pc_hold_c = 1'b1;
            fd_hold_c = 1'b1;
            de_nop_c  = 1'b1;
            if (LOAD_LAT > 1) begin
              ld_cnt_d = LD_INIT;
              state_d  = S_LDUSE;
            end
          end else if (imem_stall) begin
            pc_hold_c = 1'b1;
            fd_nop_c  = 1'b1;
          end
        end
      endcase
    end
  end

  // outputs are forced low for as long as reset is asserted
  assign pc_hold = rst & pc_hold_c;
  assign fd_hold = rst & fd_hold_c;
  assign de_hold = rst & de_hold_c;
  assign em_hold = rst & em_hold_c;
  assign fd_nop  = rst & fd_nop_c;
  assign de_nop  = rst & de_nop_c;
  assign mw_nop  = rst & mw_nop_c;
  assign halted  = rst & halted_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (pc_hold_c && (state_q != S_HALT) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc
//   Two instances share one stimulus stream:
//     A: LOAD_LAT=2, IMEM_LAT=2, ZERO_REG_HARD=1, CNT_W=16
//     B: LOAD_LAT=1, IMEM_LAT=0, ZERO_REG_HARD=0, CNT_W=4
//   A behavioural model tracks remaining bubble/squash cycles per instance and
//   is compared against every output on every falling edge; directed
//   sequences add hand-computed literal expectations.
module tb_hazard_ctrl_mc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic redirect, halt, imem_stall, dmem_stall, mem_read, rs_vld, rt_vld;
  logic [2:0] rd, rs, rt;

  logic pc_hold_a, fd_hold_a, de_hold_a, em_hold_a, fd_nop_a, de_nop_a, mw_nop_a, halted_a;
  logic pc_hold_b, fd_hold_b, de_hold_b, em_hold_b, fd_nop_b, de_nop_b, mw_nop_b, halted_b;
  logic [15:0] stall_cnt_a;
  logic [3:0]  stall_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_W(3), .LOAD_LAT(2), .IMEM_LAT(2), .ZERO_REG_HARD(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .redirect(redirect), .halt(halt),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .id_ex_mem_read(mem_read), .id_ex_rd(rd), .if_id_rs(rs), .if_id_rt(rt),
    .if_id_rs_vld(rs_vld), .if_id_rt_vld(rt_vld),
    .pc_hold(pc_hold_a), .fd_hold(fd_hold_a), .de_hold(de_hold_a), .em_hold(em_hold_a),
    .fd_nop(fd_nop_a), .de_nop(de_nop_a), .mw_nop(mw_nop_a), .halted(halted_a),
    .stall_cnt(stall_cnt_a)
  );

  hazard_ctrl_mc #(.REG_W(3), .LOAD_LAT(1), .IMEM_LAT(0), .ZERO_REG_HARD(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .redirect(redirect), .halt(halt),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .id_ex_mem_read(mem_read), .id_ex_rd(rd), .if_id_rs(rs), .if_id_rt(rt),
    .if_id_rs_vld(rs_vld), .if_id_rt_vld(rt_vld),
    .pc_hold(pc_hold_b), .fd_hold(fd_hold_b), .de_hold(de_hold_b), .em_hold(em_hold_b),
    .fd_nop(fd_nop_b), .de_nop(de_nop_b), .mw_nop(mw_nop_b), .halted(halted_b),
    .stall_cnt(stall_cnt_b)
  );

  logic [7:0] out_a, out_b;
  assign out_a = {pc_hold_a, fd_hold_a, de_hold_a, em_hold_a, fd_nop_a, de_nop_a, mw_nop_a, halted_a};
  assign out_b = {pc_hold_b, fd_hold_b, de_hold_b, em_hold_b, fd_nop_b, de_nop_b, mw_nop_b, halted_b};

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0]  ld_left;   // load-use bubbles still owed
    logic [7:0]  sq_left;   // wrong-path fetches still to squash
    logic        pend;      // redirect deferred by a memory wait
    logic        hlt;
    logic [15:0] cnt;
  } mst_t;

  function automatic void step(input int load_lat, input int imem_lat, input int zrh,
                               input int cnt_w, input logic rstv, input mst_t s,
                               output logic [7:0] o, output mst_t ns);
    logic hit, stallall, ph, fh, dh, eh, fn, dn, mn, hd;
    int   cmax;
    cmax = (1 << cnt_w) - 1;
    ns = s;
    {ph, fh, dh, eh, fn, dn, mn, hd} = 8'h00;
    hit = mem_read && ((rs_vld && rs == rd) || (rt_vld && rt == rd)) && !(zrh != 0 && rd == 3'd0);
    stallall = 1'b0;
    if (!rstv) begin
      ns = '0;
    end else if (s.hlt) begin
      stallall = 1'b1;
      hd = 1'b1;
    end else if (halt) begin
      stallall = 1'b1;
      ns.hlt = 1'b1;
    end else if (dmem_stall) begin
      stallall = 1'b1;
      ns.pend = s.pend | redirect;
    end else if (redirect || s.pend) begin
      fn = 1'b1; dn = 1'b1;
      ns.pend = 1'b0;
      ns.ld_left = 8'd0;
      ns.sq_left = 8'(imem_lat);
    end else if (s.ld_left != 8'd0) begin
      ph = 1'b1; fh = 1'b1; dn = 1'b1;
      ns.ld_left = s.ld_left - 8'd1;
    end else if (s.sq_left != 8'd0) begin
      fn = 1'b1;
      ph = imem_stall;
      ns.sq_left = s.sq_left - 8'd1;
    end else if (hit) begin
      ph = 1'b1; fh = 1'b1; dn = 1'b1;
      ns.ld_left = 8'(load_lat - 1);
    end else if (imem_stall) begin
      ph = 1'b1; fn = 1'b1;
    end
    if (stallall) begin
      {ph, fh, dh, eh} = 4'b1111;
      mn = 1'b1;
    end
    if (rstv && ph && !s.hlt && int'(s.cnt) < cmax) ns.cnt = s.cnt + 16'd1;
    o = {ph, fh, dh, eh, fn, dn, mn, hd};
  endfunction

  mst_t       ma, mb, na, nb;
  logic [7:0] ea, eb;

  always_comb begin
    step(2, 2, 1, 16, rst, ma, ea, na);
    step(1, 0, 0, 4, rst, mb, eb, nb);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= na;
      mb <= nb;
    end
  end

  always @(negedge clk) begin
    checks = checks + 2;
    if ({out_a, stall_cnt_a} !== {ea, ma.cnt}) begin
      errors = errors + 1;
      $display("FAIL model_a t=%0t: got out=%b cnt=%0d expected out=%b cnt=%0d",
               $time, out_a, stall_cnt_a, ea, ma.cnt);
    end
    if ({out_b, 12'd0, stall_cnt_b} !== {eb, mb.cnt}) begin
      errors = errors + 1;
      $display("FAIL model_b t=%0t: got out=%b cnt=%0d expected out=%b cnt=%0d",
               $time, out_b, stall_cnt_b, eb, mb.cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr();
    redirect = 0; halt = 0; imem_stall = 0; dmem_stall = 0;
    mem_read = 0; rd = 0; rs = 0; rt = 0; rs_vld = 0; rt_vld = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    clr();
    rst = 0;
    nxt();
    nxt();
    rst = 1;
  endtask

  // ---------------- directed + random ----------------
  initial begin
    logic [2:0] rdx_exp [5];
    logic       rdx_in  [5];
    logic [7:0] dw_exp  [4];

    clr();
    do_reset();
    @(negedge clk);
    lit("reset_out_a", 32'(out_a), 32'h0);
    lit("reset_cnt_a", 32'(stall_cnt_a), 32'h0);

    // load-use: A stalls 2 cycles, B stalls 1
    nxt();
    mem_read = 1; rd = 3; rs = 3; rs_vld = 1;
    @(negedge clk);
    lit("ldu_a_c0", 32'({pc_hold_a, fd_hold_a, de_nop_a}), 32'h7);
    lit("ldu_b_c0", 32'({pc_hold_b, fd_hold_b, de_nop_b}), 32'h7);
    nxt(); clr();
    @(negedge clk);
    lit("ldu_a_c1", 32'({pc_hold_a, fd_hold_a, de_nop_a}), 32'h7);
    lit("ldu_b_c1", 32'({pc_hold_b, fd_hold_b, de_nop_b}), 32'h0);
    nxt();
    @(negedge clk);
    lit("ldu_a_c2", 32'(out_a), 32'h0);
    lit("ldu_a_cnt", 32'(stall_cnt_a), 32'd2);
    lit("ldu_b_cnt", 32'(stall_cnt_b), 32'd1);
    nxt();

    // register 0 masking and rt_vld gating
    mem_read = 1; rd = 0; rs = 0; rs_vld = 1;
    @(negedge clk);
    lit("zero_a", 32'(pc_hold_a), 32'h0);
    lit("zero_b", 32'(pc_hold_b), 32'h1);
    nxt();
    mem_read = 1; rd = 5; rt = 5; rt_vld = 0; rs = 1; rs_vld = 1;
    @(negedge clk);
    lit("rtvld_a", 32'(pc_hold_a), 32'h0);
    lit("rtvld_b", 32'(pc_hold_b), 32'h0);
    nxt(); clr();

    // single redirect: {fd_nop, de_nop, pc_hold}
    do_reset();
    redirect = 1;
    @(negedge clk);
    lit("redir_a_c0", 32'({fd_nop_a, de_nop_a, pc_hold_a}), 32'h6);
    lit("redir_b_c0", 32'({fd_nop_b, de_nop_b, pc_hold_b}), 32'h6);
    nxt(); clr();
    @(negedge clk);
    lit("redir_a_c1", 32'(out_a), 32'h08);
    lit("redir_b_c1", 32'(out_b), 32'h00);
    nxt();
    @(negedge clk);
    lit("redir_a_c2", 32'(out_a), 32'h08);
    nxt();
    @(negedge clk);
    lit("redir_a_c3", 32'(out_a), 32'h00);
    nxt();

    // back-to-back redirect extends the squash
    rdx_in  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    rdx_exp = '{3'b110, 3'b110, 3'b100, 3'b100, 3'b000};
    for (int i = 0; i < 5; i++) begin
      redirect = rdx_in[i];
      @(negedge clk);
      lit($sformatf("redir2_a_c%0d", i), 32'({fd_nop_a, de_nop_a, pc_hold_a}), 32'(rdx_exp[i]));
      nxt();
    end
    clr();

    // data-memory wait with a redirect arriving mid-wait
    do_reset();
    dw_exp = '{8'hF2, 8'hF2, 8'hF2, 8'h0C};
    for (int i = 0; i < 4; i++) begin
      dmem_stall = (i < 3);
      redirect   = (i == 1);
      @(negedge clk);
      lit($sformatf("dwait_a_c%0d", i), 32'(out_a), 32'(dw_exp[i]));
      lit($sformatf("dwait_b_c%0d", i), 32'(out_b), 32'(dw_exp[i]));
      if (i < 3) nxt();
    end
    lit("dwait_cnt_a", 32'(stall_cnt_a), 32'd3);
    lit("dwait_cnt_b", 32'(stall_cnt_b), 32'd3);
    nxt(); clr();

    // halt during LDUSE, then asynchronous reset
    do_reset();
    mem_read = 1; rd = 2; rt = 2; rt_vld = 1;
    nxt(); clr();
    halt = 1;
    @(negedge clk);
    lit("halt_a_c1", 32'(out_a), 32'hF2);
    nxt(); clr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit($sformatf("halted_a_c%0d", i), 32'(out_a), 32'hF3);
      lit($sformatf("halted_b_c%0d", i), 32'(out_b), 32'hF3);
      nxt();
    end
    lit("halt_cnt_a", 32'(stall_cnt_a), 32'd2);
    lit("halt_cnt_b", 32'(stall_cnt_b), 32'd2);
    @(negedge clk);
    #1 rst = 0;
    #1;
    lit("async_rst_out_a", 32'(out_a), 32'h0);
    lit("async_rst_cnt_a", 32'(stall_cnt_a), 32'h0);
    lit("async_rst_out_b", 32'(out_b), 32'h0);
    nxt();
    rst = 1;

    // saturation on the 4-bit counter
    do_reset();
    imem_stall = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lit($sformatf("imem_b_c%0d", i), 32'({pc_hold_b, fd_nop_b}), 32'h3);
      nxt();
    end
    @(negedge clk);
    lit("sat_cnt_b", 32'(stall_cnt_b), 32'd15);
    lit("sat_cnt_a", 32'(stall_cnt_a), 32'd20);
    nxt(); clr();

    // randomized traffic checked by the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        clr();
        rst = 0;
        nxt();
        rst = 1;
      end
      halt       = ($urandom_range(0, 199) == 0);
      dmem_stall = ($urandom_range(0, 5) == 0);
      redirect   = ($urandom_range(0, 5) == 0);
      imem_stall = ($urandom_range(0, 4) == 0);
      mem_read   = $urandom_range(0, 1) == 1;
      rd         = 3'($urandom_range(0, 7));
      rs         = 3'($urandom_range(0, 7));
      rt         = 3'($urandom_range(0, 7));
      rs_vld     = $urandom_range(0, 1) == 1;
      rt_vld     = $urandom_range(0, 1) == 1;
      nxt();
    end
    clr();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised, stateful successor to the single-cycle hazard unit.
- Sits beside the 5-stage pipeline and drives hold/NOP controls for the PC and the FD/DE/EM/MW pipeline registers.
- Adds multi-cycle load-use stalls, multi-cycle data-memory wait, fetch-latency-aware branch squash, sticky halt and a saturating stall counter.

Parameters:
REG_W, 3, register-specifier width.
LOAD_LAT, 1, load-use bubble cycles (>=1).
IMEM_LAT, 1, wrong-path fetches in flight after a redirect; extra FD squash cycles (>=0).
ZERO_REG_HARD, 0, 1 means register 0 never creates a hazard.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
redirect  in  1  branch/jump taken, resolved in EX
halt  in  1  halt/dump request from decode
imem_stall  in  1  instruction memory not ready this cycle
dmem_stall  in  1  data memory busy; MEM stage must wait
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  REG_W  load destination
if_id_rs  in  REG_W  decode source 1
if_id_rt  in  REG_W  decode source 2
if_id_rs_vld  in  1  source 1 is read
if_id_rt_vld  in  1  source 2 is read
pc_hold  out  1  PC keeps its value
fd_hold  out  1  FD register keeps its value
de_hold  out  1  DE register keeps its value
em_hold  out  1  EM register keeps its value
fd_nop  out  1  FD loads a bubble
de_nop  out  1  DE loads a bubble
mw_nop  out  1  MW loads a bubble
halted  out  1  pipeline halted (sticky)
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- States: RUN, LDUSE, FLUSH, DWAIT, HALT. rst=0 forces RUN, all outputs 0, stall_cnt=0, ld_cnt=0, fl_cnt=0, redir_pend=0.
- Outputs are combinational from state and inputs. Any output not listed for a condition is 0.
- ld_hit = id_ex_mem_read & ((if_id_rs_vld & rs==rd) | (if_id_rt_vld & rt==rd)). Masked when ZERO_REG_HARD=1 and rd==0.
- Priority, evaluated each cycle: halt > dmem_stall > redirect (or redir_pend) > ld_hit/LDUSE > imem_stall.
- halt=1 in any state:
  - pc_hold=fd_hold=de_hold=em_hold=1, mw_nop=1.
  - Next state HALT; HALT is left only by reset. halted=1 in HALT.
- dmem_stall=1:
  - pc_hold=fd_hold=de_hold=em_hold=1, mw_nop=1; state DWAIT.
  - A redirect seen during DWAIT sets redir_pend; it is not acted on while stalled.
  - The first cycle with dmem_stall=0 acts on redir_pend as a redirect, then clears it.
  - An LDUSE or FLUSH in progress is frozen: counters do not decrement during DWAIT. The state resumes afterwards.
- Redirect:
  - fd_nop=1, de_nop=1 in the redirect cycle; PC is not held.
  - If IMEM_LAT>0: go to FLUSH with fl_cnt=IMEM_LAT. In FLUSH, fd_nop=1 and fl_cnt decrements each cycle; return to RUN at 0.
  - A new redirect in FLUSH reloads fl_cnt=IMEM_LAT.
  - A redirect cancels LDUSE: ld_cnt is cleared.
- Load-use, in RUN with ld_hit=1:
  - pc_hold=1, fd_hold=1, de_nop=1.
  - If LOAD_LAT>1: go to LDUSE with ld_cnt=LOAD_LAT-1. LDUSE keeps the same outputs without re-checking ld_hit, decrements ld_cnt, and returns to RUN at 0. ld_hit is re-checked in RUN.
- imem_stall=1 with no higher-priority condition: pc_hold=1, fd_nop=1.
  - Also applies in FLUSH, where fd_nop is already 1; fl_cnt still decrements.
- stall_cnt increments by 1 on every cycle with pc_hold=1 and state!=HALT. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Reset mid-operation: asynchronous. All state, counters and redir_pend clear immediately; outputs drop to 0 with no clock edge.

Test Plan:
- LOAD_LAT=2, id_ex_mem_read=1, id_ex_rd=3, if_id_rs=3, rs_vld=1 for 1 cycle -> pc_hold=fd_hold=de_nop=1 for exactly 2 cycles; stall_cnt=2; then RUN.
- ZERO_REG_HARD=1, rd=0, rs=0 load -> no stall. ZERO_REG_HARD=0, same stimulus -> 1-cycle stall. rt match with rt_vld=0 -> no stall.
- IMEM_LAT=2, redirect pulse 1 cycle -> cycle 0: fd_nop=de_nop=1, pc_hold=0; cycles 1-2: fd_nop=1 only; cycle 3: all 0. A second redirect in cycle 1 -> fd_nop extends through cycle 3.
- dmem_stall high 3 cycles with redirect in the 2nd -> holds plus mw_nop for 3 cycles; no fd_nop/de_nop during them; redirect outputs appear in the cycle dmem_stall falls; stall_cnt=3.
- halt during LDUSE -> all holds plus mw_nop, halted=1 indefinitely; stall_cnt frozen. rst=0 asynchronously clears halted, counters and outputs with no clock edge.
- CNT_W=4, 20 consecutive imem_stall cycles -> stall_cnt saturates at 15; fd_nop=pc_hold=1 throughout.
